// File: rtl/fetch_pkg.sv
// Shared widths, reset vector, buffer entry type and fetch state encoding.
// FETCH_SKID_BUFFER_EN selects a two-entry buffer; otherwise a single entry is used.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0001;

`ifdef FETCH_SKID_BUFFER_EN
  localparam int unsigned FETCH_DEPTH = 2;
`else
  localparam int unsigned FETCH_DEPTH = 1;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_STALL
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO of {pc, instr} entries with push, pop, flush and occupancy count.
// Head outputs read as zero whenever the buffer is empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ADDR_W-1:0]  pushPc,
  input  logic [INSTR_W-1:0] pushInstr,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic [ADDR_W-1:0]  headPc,
  output logic [INSTR_W-1:0] headInstr
);

  logic [ADDR_W-1:0]  pcMem    [DEPTH];
  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= bump(wrPtr);
      if (pop)  rdPtr <= bump(rdPtr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: contents are only visible through the count-gated head.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pcMem[wrPtr]    <= pushPc;
      instrMem[wrPtr] <= pushInstr;
    end
  end

  always_comb begin
    headPc    = '0;
    headInstr = '0;
    if (count != '0) begin
      headPc    = pcMem[rdPtr];
      headInstr = instrMem[rdPtr];
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register driving the ROM, buffering {PC, instr} for decode.
// Buffer depth is 2 with FETCH_SKID_BUFFER_EN defined, 1 otherwise.
module instruction_fetch #(
  parameter int unsigned       ADDR_W       = fetch_pkg::ADDR_W,
  parameter int unsigned       INSTR_W      = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  InstructionAddress,
  input  logic [INSTR_W-1:0] InstructionIn,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectTarget,
  output logic               FetchValid,
  output logic [INSTR_W-1:0] FetchInstr,
  output logic [ADDR_W-1:0]  FetchPC,
  input  logic               FetchReady
);

  import fetch_pkg::*;

  localparam int unsigned DEPTH = FETCH_DEPTH;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countNext;
  fetch_state_t      state;
  fetch_state_t      stateNext;
  logic              pop;
  logic              push;
  logic              space;

  assign InstructionAddress = pc;
  assign FetchValid         = (count != '0);
  assign pop                = FetchValid && FetchReady;
  // STALL tracks count == DEPTH, so a push is only possible there alongside a pop.
  assign space              = (state != ST_STALL) || pop;
  assign push               = !Redirect && space;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
      pc    <= RESET_VECTOR;
    end else begin
      state <= stateNext;
      if (Redirect)  pc <= RedirectTarget;
      else if (push) pc <= pc + ADDR_W'(1);
    end
  end

  always_comb begin
    countNext = count;
    stateNext = ST_RUN;
    if (!Redirect) begin
      if (push && !pop)      countNext = count + CNT_W'(1);
      else if (pop && !push) countNext = count - CNT_W'(1);
      stateNext = (countNext == CNT_W'(DEPTH)) ? ST_STALL : ST_RUN;
    end
  end

  fetch_buffer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pushPc    (pc),
    .pushInstr (InstructionIn),
    .pop       (pop),
    .flush     (Redirect),
    .count     (count),
    .headPc    (FetchPC),
    .headInstr (FetchInstr)
  );

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0001, first fetch address after reset.
REQ-002 Parameter ADDR_W, default 16, program counter and address width.
REQ-003 Parameter INSTR_W, default 16, instruction word width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 InstructionAddress  output  ADDR_W  word address driven to instruction ROM.
REQ-007 InstructionIn  input  INSTR_W  ROM data, combinationally valid for InstructionAddress in the same cycle.
REQ-008 Redirect  input  1  one-cycle pulse requesting PC change (branch/jump/return).
REQ-009 RedirectTarget  input  ADDR_W  new PC, sampled when Redirect=1.
REQ-010 FetchValid  output  1  FetchInstr/FetchPC hold a valid entry.
REQ-011 FetchInstr  output  INSTR_W  instruction at buffer head.
REQ-012 FetchPC  output  ADDR_W  address of FetchInstr.
REQ-013 FetchReady  input  1  decode accepts head entry when FetchValid=1.

Function
REQ-014 InstructionAddress SHALL equal the PC register, no combinational path from any input.
REQ-015 Push: each cycle with Redirect=0 and buffer space, {PC, InstructionIn} SHALL be written to the buffer tail and PC SHALL increment by 1.
REQ-016 Buffer space SHALL mean count < DEPTH, or count == DEPTH with a pop in the same cycle.
REQ-017 Pop: FetchValid=1 and FetchReady=1 SHALL remove the head entry at the clock edge.
REQ-018 FetchValid SHALL be 1 iff count > 0; FetchInstr/FetchPC SHALL be the head entry, don't-care while FetchValid=0.
REQ-019 Latency: an address presented in cycle N SHALL appear on FetchInstr in cycle N+1 when the buffer was empty.
REQ-020 Full (no space): PC and InstructionAddress SHALL hold; no entry lost or duplicated.
REQ-021 PC increment SHALL wrap 16'hFFFF -> 16'h0000 modulo 2^ADDR_W with no flag.
REQ-022 Redirect=1 SHALL, at that edge, flush all entries (count -> 0), set PC to RedirectTarget, and suppress push; a concurrent pop SHALL be discarded harmlessly.
REQ-023 Cycle after Redirect: FetchValid=0, InstructionAddress=RedirectTarget; next cycle FetchValid=1 with FetchPC=RedirectTarget.
REQ-024 Back-to-back Redirect pulses SHALL each take effect; last one wins.
REQ-025 State machine: RESET (in rst), RUN (count < DEPTH), STALL (count == DEPTH, no pop); RUN->STALL on fill, STALL->RUN on pop, any->RUN on Redirect.
REQ-026 Entries SHALL leave in fetch order; FetchPC of consecutive entries SHALL differ by exactly 1 absent a Redirect.

Reset
REQ-027 While rst=1: PC=RESET_VECTOR, count=0, FetchValid=0, FetchInstr=0, FetchPC=0, InstructionAddress=RESET_VECTOR.
REQ-028 Reset asserted mid-operation SHALL immediately discard buffered entries and pending redirects.
REQ-029 First edge after rst deasserts SHALL push ROM[RESET_VECTOR].

Configuration
REQ-030 Macro FETCH_SKID_BUFFER_EN defined: DEPTH=2, full throughput with FetchReady registered in decode.
REQ-031 Macro undefined: DEPTH=1; push only when empty or popping same cycle; all other requirements unchanged.

Structure
REQ-032 Package fetch_pkg SHALL hold ADDR_W, INSTR_W, default RESET_VECTOR, fetch_entry_t {pc, instr}, and the state enum.
REQ-033 Buffer SHALL be sub-module fetch_buffer (parameterised DEPTH, push/pop/flush, count).

Verification
REQ-034 Reset release, ROM 1:C123 2:E185 3:D733, FetchReady=1 -> FetchPC 1,2,3 / FetchInstr C123,E185,D733 on consecutive cycles.
REQ-035 FetchReady=0 for 5 cycles -> with EN, count 2, InstructionAddress holds at 3; on release C123,E185,D733 in order, no gaps.
REQ-036 Redirect with target 000A while 2 entries held -> FetchValid=0 next cycle, then FetchPC=000A, old entries never seen.
REQ-037 PC forced to FFFF by Redirect -> following FetchPC FFFF, 0000, 0001.
REQ-038 rst pulsed while full and Redirect=1 -> FetchValid=0, InstructionAddress=0001, first entry after release is PC 0001.
REQ-039 Without EN, FetchReady toggling 1,0,1,0 -> each entry delivered exactly once, PCs strictly sequential.
